// File: rtl/bcd_counter4.sv
// bcd_counter4: four-digit up/down BCD counter with prescaler and load.
// Ports: clk, rst (sync, active-low), en, up, load, Din[15:0]
//        -> D0 (thousands) .. D3 (units), co (one-cycle wrap pulse).
module bcd_counter4 #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] Din,
  output logic [3:0]  D0,
  output logic [3:0]  D1,
  output logic [3:0]  D2,
  output logic [3:0]  D3,
  output logic        co
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0]  r_pre;
  logic [3:0]     r_d0, r_d1, r_d2, r_d3;
  logic           r_co;

  logic           w_step;
  logic           w_k;
  logic [3:0][3:0] w_cur;
  logic [3:0][3:0] w_nxt;

  // Nibbles above 9 are not BCD; they load as 0.
  function automatic logic [3:0] san(input logic [3:0] n);
    return (n > 4'd9) ? 4'd0 : n;
  endfunction

  assign w_step = en & ~load & (r_pre == LAST);

  // Index 0 is the units digit; w_k is the carry/borrow
  // rippling upward, and is the wrap flag once it leaves D0.
  assign w_cur = {r_d0, r_d1, r_d2, r_d3};

  always_comb begin
    w_nxt = w_cur;
    w_k   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_k) begin
        if (up) begin
          if (w_cur[i] >= 4'd9) begin
            w_nxt[i] = 4'd0;
          end else begin
            w_nxt[i] = w_cur[i] + 4'd1;
            w_k      = 1'b0;
          end
        end else begin
          if (w_cur[i] == 4'd0) begin
            w_nxt[i] = 4'd9;
          end else begin
            w_nxt[i] = w_cur[i] - 4'd1;
            w_k      = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pre <= '0;
      r_d0  <= 4'd0;
      r_d1  <= 4'd0;
      r_d2  <= 4'd0;
      r_d3  <= 4'd0;
      r_co  <= 1'b0;
    end else if (load) begin
      r_pre <= '0;
      r_d0  <= san(Din[15:12]);
      r_d1  <= san(Din[11:8]);
      r_d2  <= san(Din[7:4]);
      r_d3  <= san(Din[3:0]);
      r_co  <= 1'b0;
    end else if (en) begin
      r_pre <= w_step ? '0 : r_pre + PW'(1);
      r_co  <= w_step & w_k;
      if (w_step) begin
        r_d0 <= w_nxt[3];
        r_d1 <= w_nxt[2];
        r_d2 <= w_nxt[1];
        r_d3 <= w_nxt[0];
      end
    end else begin
      r_co <= 1'b0;
    end
  end

  assign D0 = r_d0;
  assign D1 = r_d1;
  assign D2 = r_d2;
  assign D3 = r_d3;
  assign co = r_co;

endmodule

// File: tb/tb_bcd_counter4.sv
// tb_bcd_counter4: scoreboard bench for bcd_counter4 at DIV=4.
// Stimulus queues expected digits/co per cycle; a monitor compares.
module tb_bcd_counter4;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] Din;
  logic [3:0]  D0, D1, D2, D3;
  logic        co;

  bcd_counter4 #(.DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .Din  (Din),
    .D0   (D0),
    .D1   (D1),
    .D2   (D2),
    .D3   (D3),
    .co   (co)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic        c;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic done = 1'b0;

  // Expect state {D0,D1,D2,D3}/co after posedge number cyc+after.
  task automatic push(input string nm, input logic [15:0] d,
                      input logic c, input int after);
    exp_t e;
    int   i;
    e.cyc = cyc + after;
    e.d   = d;
    e.c   = c;
    e.nm  = nm;
    i = 0;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    logic [15:0] act;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      act = {D0, D1, D2, D3};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: stale check for cycle %0d at %0d",
                   e.nm, e.cyc, cyc);
        end else if (act !== e.d || co !== e.c) begin
          errors++;
          $display("FAIL %s: got digits=%h co=%b, need %h co=%b",
                   e.nm, act, co, e.d, e.c);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; Din = 16'h0;
    push("rst1", 16'h0000, 1'b0, 1);
    push("rst2", 16'h0000, 1'b0, 2);
    run(2);
    rst = 1'b1;
    push("first_hold", 16'h0000, 1'b0, 3);
    push("first_step", 16'h0001, 1'b0, 4);
    push("second_step", 16'h0002, 1'b0, 8);
    run(8);

    load = 1'b1; Din = 16'h0999;
    push("ld0999", 16'h0999, 1'b0, 1);
    run(1);
    load = 1'b0;
    push("ripple_hold", 16'h0999, 1'b0, 3);
    push("ripple", 16'h1000, 1'b0, 4);
    push("ripple_co", 16'h1000, 1'b0, 5);
    run(5);

    load = 1'b1; Din = 16'h9999;
    push("ld9999", 16'h9999, 1'b0, 1);
    run(1);
    load = 1'b0;
    push("upwrap_hold", 16'h9999, 1'b0, 3);
    push("upwrap", 16'h0000, 1'b1, 4);
    push("upwrap_co_end", 16'h0000, 1'b0, 5);
    run(5);

    load = 1'b1; Din = 16'h0000; up = 1'b0;
    push("ld0000", 16'h0000, 1'b0, 1);
    run(1);
    load = 1'b0;
    push("dnwrap", 16'h9999, 1'b1, 4);
    push("dnwrap_co_end", 16'h9999, 1'b0, 5);
    push("dn_hold", 16'h9999, 1'b0, 7);
    push("dn_step", 16'h9998, 1'b0, 8);
    push("dn_no_co", 16'h9998, 1'b0, 9);
    run(9);

    up = 1'b1; load = 1'b1; Din = 16'h1A3F;
    push("ld_sanit", 16'h1030, 1'b0, 1);
    run(1);
    load = 1'b0;
    push("en_gap_hold", 16'h1030, 1'b0, 5);
    push("en_gap_hold2", 16'h1030, 1'b0, 6);
    push("en_gap_step", 16'h1031, 1'b0, 7);
    run(2);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(2);

    load = 1'b1; Din = 16'hB7C9;
    push("ld_sanit2", 16'h0709, 1'b0, 1);
    run(1);
    load = 1'b0;
    run(3);
    load = 1'b1; Din = 16'h0042;
    push("ld_vs_step", 16'h0042, 1'b0, 1);
    run(1);
    load = 1'b0;
    push("after_ld_hold", 16'h0042, 1'b0, 3);
    push("after_ld_step", 16'h0043, 1'b0, 4);
    run(4);

    load = 1'b1; Din = 16'h0050;
    push("ld0050", 16'h0050, 1'b0, 1);
    run(1);
    load = 1'b0;
    push("dir_phase", 16'h0051, 1'b0, 4);
    up = 1'b0;
    run(2);
    up = 1'b1;
    run(2);

    rst = 1'b0; load = 1'b1; Din = 16'h5555;
    push("rst_over_ld", 16'h0000, 1'b0, 1);
    run(1);
    rst = 1'b1; load = 1'b0;
    run(2);
    rst = 1'b0;
    run(1);
    rst = 1'b1;
    push("rst_mid_hold", 16'h0000, 1'b0, 3);
    push("rst_mid_step", 16'h0001, 1'b0, 4);
    run(6);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d checks left, need 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
